// File: rtl/host_reg_if_pkg.sv
// Register map offsets, event bit positions and host address decode
// shared by the SD host register interface.
package host_reg_if_pkg;

    localparam logic [31:0] OFF_BLK     = 32'h0000_0004;
    localparam logic [31:0] OFF_ARG     = 32'h0000_0008;
    localparam logic [31:0] OFF_CMD     = 32'h0000_000C;
    localparam logic [31:0] OFF_RESP    = 32'h0000_0010;
    localparam logic [31:0] OFF_PSTATE  = 32'h0000_0024;
    localparam logic [31:0] OFF_BGAP    = 32'h0000_0028;
    localparam logic [31:0] OFF_SWRST   = 32'h0000_002C;
    localparam logic [31:0] OFF_INTSTS  = 32'h0000_0030;
    localparam logic [31:0] OFF_INTEN   = 32'h0000_0034;
    localparam logic [31:0] OFF_ADMA_LO = 32'h0000_0058;
    localparam logic [31:0] OFF_ADMA_HI = 32'h0000_005C;

    localparam int NIS_CMD_DONE    = 0;
    localparam int NIS_XFER_DONE   = 1;
    localparam int EIS_CMD_TIMEOUT = 0;
    localparam int EIS_ADMA_ERR    = 9;
    localparam int SRA_BIT         = 24;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_BLK,
        SEL_ARG,
        SEL_CMD,
        SEL_RESP,
        SEL_PSTATE,
        SEL_BGAP,
        SEL_SWRST,
        SEL_INTSTS,
        SEL_INTEN,
        SEL_ADMA_LO,
        SEL_ADMA_HI
    } reg_sel_e;

    // Byte address in, register select out; the two low address bits are don't-care.
    function automatic reg_sel_e decode_addr(input logic [31:0] i_addr);
        reg_sel_e w_sel;
        case (i_addr & 32'hFFFF_FFFC)
            OFF_BLK:     w_sel = SEL_BLK;
            OFF_ARG:     w_sel = SEL_ARG;
            OFF_CMD:     w_sel = SEL_CMD;
            OFF_RESP:    w_sel = SEL_RESP;
            OFF_PSTATE:  w_sel = SEL_PSTATE;
            OFF_BGAP:    w_sel = SEL_BGAP;
            OFF_SWRST:   w_sel = SEL_SWRST;
            OFF_INTSTS:  w_sel = SEL_INTSTS;
            OFF_INTEN:   w_sel = SEL_INTEN;
            OFF_ADMA_LO: w_sel = SEL_ADMA_LO;
            OFF_ADMA_HI: w_sel = SEL_ADMA_HI;
            default:     w_sel = SEL_NONE;
        endcase
        return w_sel;
    endfunction

endpackage

// File: rtl/host_reg_if_w1c_status16.sv
// 16-bit interrupt status: events set bits, host write-1 clears them (set wins),
// plus the matching enable register and the masked pending flag.
module w1c_status16 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_evt,
    input  logic        i_clr_we,
    input  logic [15:0] i_clr_data,
    input  logic        i_en_we,
    input  logic [15:0] i_en_data,
    output logic [15:0] o_status,
    output logic [15:0] o_en,
    output logic        o_pend
);

    logic [15:0] r_status;
    logic [15:0] r_en;
    logic [15:0] w_clr;

    assign w_clr = i_clr_we ? i_clr_data : 16'h0000;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_status <= 16'h0000;
            r_en     <= 16'h0000;
        end else begin
            r_status <= (r_status & ~w_clr) | i_evt;
            if (i_en_we) begin
                r_en <= i_en_data;
            end
        end
    end

    assign o_status = r_status;
    assign o_en     = r_en;
    assign o_pend   = |(r_status & r_en);

endmodule

// File: rtl/host_reg_if.sv
// SD host register bus interface: register map decode, engine control registers,
// W1C interrupt status, registered read port and software reset.
module host_reg_if
    import host_reg_if_pkg::*;
#(
    parameter int ADDR_W         = 13,
    parameter bit CMD_INHIBIT_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] addrs,
    input  logic [31:0]       wr_data,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic [15:0]       blk_size,
    output logic [15:0]       blk_count,
    output logic [31:0]       cmd_arg,
    output logic [15:0]       xfer_mode,
    output logic [15:0]       command,
    output logic [15:0]       blk_gap_ctrl,
    output logic [63:0]       adma_addr,
    output logic              cmd_issue,
    output logic              sw_rst,
    input  logic              cmd_busy,
    input  logic [31:0]       present_state,
    input  logic              resp_load,
    input  logic [31:0]       resp_data,
    input  logic [15:0]       nis_evt,
    input  logic [15:0]       eis_evt,
    output logic              irq,
    output logic              wr_reject
);

    reg_sel_e    w_sel;
    logic        w_rst;
    logic        w_cmd_wr;
    logic        w_cmd_rej;
    logic        w_cmd_ok;
    logic        w_sts_we;
    logic        w_en_we;
    logic [15:0] w_nis;
    logic [15:0] w_eis;
    logic [15:0] w_nis_en;
    logic [15:0] w_eis_en;
    logic        w_nis_pend;
    logic        w_eis_pend;
    logic [31:0] w_rd_mux;

    logic [15:0] r_blk_size;
    logic [15:0] r_blk_count;
    logic [31:0] r_cmd_arg;
    logic [15:0] r_xfer_mode;
    logic [15:0] r_command;
    logic [15:0] r_bgap;
    logic [63:0] r_adma;
    logic [31:0] r_resp;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_cmd_issue;
    logic        r_sw_rst;
    logic        r_irq;
    logic        r_wr_reject;

    // The sw_rst pulse cycle acts exactly like an external reset on the following edge.
    assign w_rst     = RESET | r_sw_rst;
    assign w_sel     = decode_addr({{(32-ADDR_W){1'b0}}, addrs});
    assign w_cmd_wr  = wr_en && (w_sel == SEL_CMD);
    assign w_cmd_rej = w_cmd_wr && CMD_INHIBIT_EN && cmd_busy;
    assign w_cmd_ok  = w_cmd_wr && !w_cmd_rej;
    assign w_sts_we  = wr_en && (w_sel == SEL_INTSTS);
    assign w_en_we   = wr_en && (w_sel == SEL_INTEN);

    w1c_status16 u_nis (
        .i_clk      (CLK),
        .i_rst      (w_rst),
        .i_evt      (nis_evt),
        .i_clr_we   (w_sts_we),
        .i_clr_data (wr_data[15:0]),
        .i_en_we    (w_en_we),
        .i_en_data  (wr_data[15:0]),
        .o_status   (w_nis),
        .o_en       (w_nis_en),
        .o_pend     (w_nis_pend)
    );

    w1c_status16 u_eis (
        .i_clk      (CLK),
        .i_rst      (w_rst),
        .i_evt      (eis_evt),
        .i_clr_we   (w_sts_we),
        .i_clr_data (wr_data[31:16]),
        .i_en_we    (w_en_we),
        .i_en_data  (wr_data[31:16]),
        .o_status   (w_eis),
        .o_en       (w_eis_en),
        .o_pend     (w_eis_pend)
    );

    always_comb begin
        w_rd_mux = 32'h0;
        case (w_sel)
            SEL_BLK:     w_rd_mux = {r_blk_count, r_blk_size};
            SEL_ARG:     w_rd_mux = r_cmd_arg;
            SEL_CMD:     w_rd_mux = {r_command, r_xfer_mode};
            SEL_RESP:    w_rd_mux = r_resp;
            SEL_PSTATE:  w_rd_mux = present_state;
            SEL_BGAP:    w_rd_mux = {16'h0000, r_bgap};
            SEL_INTSTS:  w_rd_mux = {w_eis, w_nis};
            SEL_INTEN:   w_rd_mux = {w_eis_en, w_nis_en};
            SEL_ADMA_LO: w_rd_mux = r_adma[31:0];
            SEL_ADMA_HI: w_rd_mux = r_adma[63:32];
            default:     w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_rst) begin
            r_blk_size  <= 16'h0;
            r_blk_count <= 16'h0;
            r_cmd_arg   <= 32'h0;
            r_xfer_mode <= 16'h0;
            r_command   <= 16'h0;
            r_bgap      <= 16'h0;
            r_adma      <= 64'h0;
            r_resp      <= 32'h0;
            r_rd_data   <= 32'h0;
            r_rd_valid  <= 1'b0;
            r_cmd_issue <= 1'b0;
            r_sw_rst    <= 1'b0;
            r_irq       <= 1'b0;
            r_wr_reject <= 1'b0;
        end else begin
            r_rd_valid  <= rd_en;
            r_rd_data   <= rd_en ? w_rd_mux : 32'h0;
            r_cmd_issue <= w_cmd_ok;
            r_sw_rst    <= wr_en && (w_sel == SEL_SWRST) && wr_data[SRA_BIT];
            r_irq       <= w_nis_pend | w_eis_pend;
            if (w_cmd_rej) begin
                r_wr_reject <= 1'b1;
            end else if (w_cmd_ok) begin
                r_wr_reject <= 1'b0;
            end
            if (resp_load) begin
                r_resp <= resp_data;
            end
            if (wr_en) begin
                case (w_sel)
                    SEL_BLK:     {r_blk_count, r_blk_size} <= wr_data;
                    SEL_ARG:     r_cmd_arg <= wr_data;
                    SEL_CMD:     if (w_cmd_ok) {r_command, r_xfer_mode} <= wr_data;
                    SEL_BGAP:    r_bgap <= wr_data[15:0];
                    SEL_ADMA_LO: r_adma[31:0] <= wr_data;
                    SEL_ADMA_HI: r_adma[63:32] <= wr_data;
                    default:     ;
                endcase
            end
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign blk_size     = r_blk_size;
    assign blk_count    = r_blk_count;
    assign cmd_arg      = r_cmd_arg;
    assign xfer_mode    = r_xfer_mode;
    assign command      = r_command;
    assign blk_gap_ctrl = r_bgap;
    assign adma_addr    = r_adma;
    assign cmd_issue    = r_cmd_issue;
    assign sw_rst       = r_sw_rst;
    assign irq          = r_irq;
    assign wr_reject    = r_wr_reject;

endmodule

// File: doc/host_reg_if.md
# host_reg_if

Host-side register bus interface for the SD host controller. Decodes the 13-bit host byte address (`addrs`, `wr_data`, `rd_data`) into the SD-host register map. Holds the host-writable registers and drives them to the DMA, CMD and DAT engines. Latches event pulses from those engines into write-1-to-clear interrupt status, and raises a single interrupt line. Sits directly upstream of the register bank and engine control inputs.

## Interface
- `ADDR_W`, 13: host byte-address width; accesses are 32-bit, `addrs[1:0]` ignored.
- `CMD_INHIBIT_EN`, 1: when 1, Command writes are rejected while `cmd_busy` is high.
- `CLK` in 1: host clock; all logic on rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `addrs` in ADDR_W: host byte address.
- `wr_data` in 32: host write data.
- `wr_en` in 1: write strobe, one access per cycle.
- `rd_en` in 1: read strobe.
- `rd_data` out 32: read data, valid when `rd_valid`.
- `rd_valid` out 1: one-cycle pulse, read data valid.
- `blk_size` out 16: Block Size register.
- `blk_count` out 16: Block Count register.
- `cmd_arg` out 32: Argument register.
- `xfer_mode` out 16: Transfer Mode register.
- `command` out 16: Command register.
- `blk_gap_ctrl` out 16: Block Gap Control register.
- `adma_addr` out 64: ADMA System Address.
- `cmd_issue` out 1: one-cycle pulse after an accepted Command write.
- `sw_rst` out 1: one-cycle Software-Reset-All pulse.
- `cmd_busy` in 1: CMD line busy (Present State bit 0).
- `present_state` in 32: read-only Present State value.
- `resp_load` in 1: load `resp_data` into Response.
- `resp_data` in 32: response word from CMD.
- `nis_evt` in 16: normal-interrupt event pulses (bit0 cmd complete, bit1 transfer complete).
- `eis_evt` in 16: error-interrupt event pulses (bit0 cmd timeout, bit9 ADMA error).
- `irq` out 1: registered interrupt request.
- `wr_reject` out 1: sticky; a Command write was rejected.

## Operation
- Register map (word offsets): 0x04 {blk_count, blk_size}; 0x08 cmd_arg; 0x0C {command, xfer_mode}; 0x10 Response (RO); 0x24 present_state (RO); 0x28 {16'h0, blk_gap_ctrl}; 0x2C bit24 SRA (write-only, reads 0); 0x30 {EIS, NIS} W1C; 0x34 {EIS_EN, NIS_EN}; 0x58 adma_addr[31:0]; 0x5C adma_addr[63:32].
- Unmapped reads return 0. Unmapped writes are ignored.
- Command write at 0x0C with `cmd_busy`=1 and `CMD_INHIBIT_EN`=1: the whole word is dropped (xfer_mode also unchanged), `wr_reject` is set, and no `cmd_issue` is generated. A write to 0x0C clears `wr_reject` only when it is accepted.
- Status bit set: `evt` bit high. Status bit clear: host writes 1 to that bit at 0x30. Set and clear in the same cycle: set wins.
- `irq` = registered |((NIS & NIS_EN) | (EIS & EIS_EN)).
- `resp_load` overwrites Response. A same-cycle host read returns the old value.
- SRA write: `sw_rst` pulses the next cycle. All registers, status, `wr_reject` and `irq` then return to reset values, exactly as `RESET` does.

## Timing
- Write: the register updates at the edge that samples `wr_en`.
- `cmd_issue` is asserted the cycle after an accepted Command write.
- Read: `rd_data`/`rd_valid` are registered, one cycle after `rd_en`.
- Read and write in the same cycle at the same address: the read returns the pre-write value.
- Reset values: all outputs are 0, including `rd_data`, `rd_valid`, `irq`, `cmd_issue`, `sw_rst` and `wr_reject`.
- `RESET` in the same cycle as a write: reset wins.
- Interrupt path: event at cycle N, status bit set at N+1, `irq` at N+2.

## Structure
- Shared package/defines: register offset constants, NIS/EIS bit indices, SRA bit position.
- One natural sub-module, `w1c_status16`: 16-bit status with set-priority W1C and enable masking. Instantiate it twice (NIS, EIS).

## Test plan
- Write 0x04=0x0003_0200, read back -> `rd_data`=0x00030200 one cycle later; `blk_size`=0x0200, `blk_count`=3.
- Write 0x0C=0x1100_0013 with `cmd_busy`=0 -> `command`=0x1100, `xfer_mode`=0x0013, `cmd_issue` pulse next cycle. Repeat with `cmd_busy`=1 -> registers unchanged, no pulse, `wr_reject`=1.
- `nis_evt`=0x0001 pulse with NIS_EN=0x0001 -> status 0x0001, `irq`=1 two cycles later. Write 0x30=0x0000_0001 -> status 0, `irq` drops. Clear coinciding with a new event -> bit stays 1.
- `resp_load` with `resp_data`=0xDEADBEEF while reading 0x10 -> read returns the old value; the next read returns 0xDEADBEEF.
- Write 0x2C=0x0100_0000 after loading all registers -> `sw_rst` one pulse, then every output reads 0. Mid-operation `RESET` behaves identically.
- Read 0x1FC (unmapped) -> 0. Write 0x5C=0x1, then 0x58=0x2 -> `adma_addr`=64'h0000_0001_0000_0002.
